// File: rtl/display_compositor_pkg.sv
// Shared constants and types for the display compositor and its raster timing.
package display_compositor_pkg;

  localparam int PIX_W = 24;

  // 640x480 @ 800x525 raster
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_TOTAL  = 525;

  // Camera window size
  localparam int DEF_WIN_W = 320;
  localparam int DEF_WIN_H = 240;

  // Shown in place of a camera pixel the FIFO could not supply
  localparam logic [PIX_W-1:0] SUB_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } comp_state_e;

  // Limit a window edge so the whole window stays on the active area
  function automatic logic [9:0] clamp_edge(input logic [9:0] edge_in, input logic [9:0] lim);
    return (edge_in > lim) ? lim : edge_in;
  endfunction

endpackage

// File: rtl/display_compositor_ctrl_raster_timing.sv
// Free-running h/v raster counters with stage-0 de/sync/last-pixel flags.
// The flags are combinational from the counters so that a consumer can
// pipeline them alongside its own data path.
module raster_timing
  import display_compositor_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       last_pix,
  output logic       frame_wrap
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;

  // Next counter values and wrap detection
  always_comb begin
    h_wrap     = (h_q == 10'(H_TOTAL - 1));
    frame_wrap = h_wrap && (v_q == 10'(V_TOTAL - 1));
    h_d        = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d        = v_q;
    if (h_wrap) begin
      v_d = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 timing flags
  always_comb begin
    de       = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    hsync    = (h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    vsync    = (v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
    last_pix = (h_q == 10'(H_ACTIVE - 1)) && (v_q == 10'(V_ACTIVE - 1));
  end

  assign h_count = h_q;
  assign v_count = v_q;

endmodule

// File: rtl/display_compositor_ctrl.sv
// Display compositor: raster generation, camera-window FIFO reads and a
// two-stage pixel pipeline muxing camera, background and substitute colour.
//
// Config (mode, window origin) is captured on the edge that wraps the raster
// to (0,0), so the values in force at pixel (0,0) hold for the whole frame.
// The frame that starts out of reset is always background-only (IDLE).
module display_compositor_ctrl
  import display_compositor_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WIN_H    = DEF_WIN_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [9:0]       win_x,
  input  logic [9:0]       win_y,
  output logic [9:0]       h_count,
  output logic [9:0]       v_count,
  input  logic [PIX_W-1:0] bg_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [PIX_W-1:0] fifo_dout,
  output logic [PIX_W-1:0] pix_out,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_done,
  output logic [15:0]      underflow_cnt
);

  localparam logic [9:0]  WX_MAX  = 10'(H_ACTIVE - WIN_W);
  localparam logic [9:0]  WY_MAX  = 10'(V_ACTIVE - WIN_H);
  localparam logic [10:0] WIN_W11 = 11'(WIN_W);
  localparam logic [10:0] WIN_H11 = 11'(WIN_H);

  logic de0, hs0, vs0, last0, frame_wrap;

  raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .de        (de0),
    .hsync     (hs0),
    .vsync     (vs0),
    .last_pix  (last0),
    .frame_wrap(frame_wrap)
  );

  comp_state_e state_q, state_d;
  logic        mode_q, mode_d;
  logic [9:0]  wx_q, wx_d;
  logic [9:0]  wy_q, wy_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic        in_win, rd0, sub0;

  // Window hit and read / substitute decision for the current pixel
  always_comb begin
    in_win = mode_q
          && ({1'b0, h_count} >= {1'b0, wx_q}) && ({1'b0, h_count} < ({1'b0, wx_q} + WIN_W11))
          && ({1'b0, v_count} >= {1'b0, wy_q}) && ({1'b0, v_count} < ({1'b0, wy_q} + WIN_H11));
    rd0    = (state_q == ST_RUN) && in_win && !fifo_empty;
    sub0   = (state_q == ST_RUN) && in_win && fifo_empty;
  end

  assign fifo_rd_en = rd0;

  // Next state, config latch and underflow count
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    ucnt_d  = ucnt_q;
    if (sub0) begin
      state_d = ST_DROP;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
    if (frame_wrap) begin
      state_d = ST_RUN;
      mode_d  = mode;
      wx_d    = clamp_edge(win_x, WX_MAX);
      wy_d    = clamp_edge(win_y, WY_MAX);
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;

  logic [PIX_W-1:0] bg1_q, bg1_d, pix_q, pix_d;
  logic rd1_q, rd1_d, sub1_q, sub1_d, de1_q, de1_d, hs1_q, hs1_d;
  logic vs1_q, vs1_d, last1_q, last1_d;
  logic de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, fd_q, fd_d;

  // Pipeline next values; FIFO data arrives during stage 1
  always_comb begin
    bg1_d   = bg_data;
    rd1_d   = rd0;
    sub1_d  = sub0;
    de1_d   = de0;
    hs1_d   = hs0;
    vs1_d   = vs0;
    last1_d = last0;
    pix_d   = '0;
    if (de1_q) pix_d = sub1_q ? SUB_COLOR : (rd1_q ? fifo_dout : bg1_q);
    de2_d   = de1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    fd_d    = last1_q;
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bg1_q   <= '0;
      rd1_q   <= 1'b0;
      sub1_q  <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      last1_q <= 1'b0;
      pix_q   <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      bg1_q   <= bg1_d;
      rd1_q   <= rd1_d;
      sub1_q  <= sub1_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      last1_q <= last1_d;
      pix_q   <= pix_d;
      de2_q   <= de2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      fd_q    <= fd_d;
    end
  end

  assign pix_out    = pix_q;
  assign de         = de2_q;
  assign hsync      = hs2_q;
  assign vsync      = vs2_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_compositor_ctrl.sv
// Bench for display_compositor_ctrl on a shrunken raster (24x16, window 6x4).
module tb_display_compositor_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HT = 24;
  localparam int VA = 12, VF = 1, VS = 2, VT = 16;
  localparam int WW = 6, WH = 4;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  win_x = '0, win_y = '0;
  logic [9:0]  h_count, v_count;
  logic [23:0] bg_data;
  logic        fifo_empty = 1'b0;
  logic        fifo_rd_en;
  logic [23:0] fifo_dout = '0;
  logic [23:0] pix_out;
  logic        de, hsync, vsync, frame_done;
  logic [15:0] underflow_cnt;

  // Background generator: pixel encodes its own coordinates
  assign bg_data = {4'hA, h_count, v_count};

  always #5 clk = ~clk;

  display_compositor_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT),
    .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .win_x(win_x), .win_y(win_y),
    .h_count(h_count), .v_count(v_count), .bg_data(bg_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .pix_out(pix_out), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_done(frame_done), .underflow_cnt(underflow_cnt)
  );

  typedef struct packed {
    logic [23:0] pix;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fd;
  } out_t;

  out_t sb[$];
  int total = 0;
  int bad = 0;

  // reference model
  int hm, vm, st, ml, wxl, wyl, ucnt;
  logic [23:0] exp_word = 24'h100000;
  logic [23:0] fifo_word = 24'h100000;
  int cyc = 0, last_fd_cyc = -1, fd_period = 0;
  int frame_reads = 0, first_h = -1, first_v = -1, last_h = -1, last_v = -1;
  bit empty_armed = 0;
  int ex = 0, ey = 0;

  task automatic reset_model();
    hm = 0; vm = 0; st = 0; ml = 0; wxl = 0; wyl = 0; ucnt = 0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    fifo_empty = 1'b0;
    empty_armed = 0;
    last_fd_cyc = -1;
    fd_period = 0;
  endtask

  // One pixel clock: check outputs, predict, advance model and FIFO
  task automatic step();
    out_t got, want;
    bit inwin, mrd, msub, mde, drd;
    @(negedge clk);
    cyc++;
    got  = {pix_out, de, hsync, vsync, frame_done};
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL pipe_out at model (%0d,%0d): got %h want %h", hm, vm, got, want);
    end
    total++;
    if ({h_count, v_count} !== {10'(hm), 10'(vm)}) begin
      bad++;
      $display("FAIL raster: got (%0d,%0d) want (%0d,%0d)", h_count, v_count, hm, vm);
    end
    total++;
    if (underflow_cnt !== 16'(ucnt)) begin
      bad++;
      $display("FAIL underflow_cnt: got %0d want %0d", underflow_cnt, ucnt);
    end
    inwin = (ml != 0) && hm >= wxl && hm < wxl + WW && vm >= wyl && vm < wyl + WH;
    mrd   = (st == 1) && inwin && !fifo_empty;
    msub  = (st == 1) && inwin && fifo_empty;
    total++;
    if (fifo_rd_en !== mrd) begin
      bad++;
      $display("FAIL rd_en at (%0d,%0d): got %b want %b", hm, vm, fifo_rd_en, mrd);
    end
    mde = (hm < HA) && (vm < VA);
    want.pix = !mde ? 24'h0 : (msub ? 24'hFF00FF : (mrd ? exp_word : {4'hA, 10'(hm), 10'(vm)}));
    want.de  = mde;
    want.hs  = (hm >= HA + HF) && (hm < HA + HF + HS);
    want.vs  = (vm >= VA + VF) && (vm < VA + VF + VS);
    want.fd  = (hm == HA - 1) && (vm == VA - 1);
    sb.push_back(want);
    if (hm == 0 && vm == 0) begin
      frame_reads = 0; first_h = -1; first_v = -1; last_h = -1; last_v = -1;
    end
    drd = fifo_rd_en;
    if (drd) begin
      frame_reads++;
      if (first_h < 0) begin first_h = hm; first_v = vm; end
      last_h = hm; last_v = vm;
    end
    if (frame_done === 1'b1) begin
      if (last_fd_cyc >= 0) fd_period = cyc - last_fd_cyc;
      last_fd_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (drd) begin
      fifo_dout = fifo_word;
      fifo_word = fifo_word + 24'd1;
    end
    if (mrd) exp_word = exp_word + 24'd1;
    if (msub) begin
      st = 2;
      if (ucnt < 65535) ucnt++;
    end
    if (hm == HT - 1 && vm == VT - 1) begin
      st  = 1;
      ml  = mode;
      wxl = (win_x > 10'(HA - WW)) ? HA - WW : int'(win_x);
      wyl = (win_y > 10'(VA - WH)) ? VA - WH : int'(win_y);
    end
    hm++;
    if (hm == HT) begin
      hm = 0;
      vm++;
      if (vm == VT) vm = 0;
    end
    fifo_empty = empty_armed && hm == ex && vm == ey;
    if (fifo_empty) empty_armed = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if ({h_count, v_count, fifo_rd_en, pix_out, de, hsync, vsync, frame_done, underflow_cnt} !== '0) begin
      bad++;
      $display("FAIL %s zero: h=%0d v=%0d rd=%b pix=%h de=%b hs=%b vs=%b fd=%b uc=%0d want all 0",
               tag, h_count, v_count, fifo_rd_en, pix_out, de, hsync, vsync, frame_done, underflow_cnt);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    // used only to format; each caller counts its own comparison
    $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic check_window(input string tag, input int reads, input int fh, input int fv);
    total++;
    if (frame_reads !== reads) begin bad++; check_int({tag, " reads"}, frame_reads, reads); end
    total++;
    if (first_h !== fh || first_v !== fv) begin
      bad++;
      $display("FAIL %s first_read: got (%0d,%0d) want (%0d,%0d)", tag, first_h, first_v, fh, fv);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
  endtask

  task automatic test_mode0();
    mode = 1'b0;
    run(FRAME);
    total++;
    if (frame_reads !== 0) begin bad++; check_int("idle_frame reads", frame_reads, 0); end
    run(FRAME);
    total++;
    if (frame_reads !== 0) begin bad++; check_int("mode0 reads", frame_reads, 0); end
    total++;
    if (fd_period !== FRAME) begin bad++; check_int("frame_done period", fd_period, FRAME); end
  endtask

  task automatic test_window();
    mode = 1'b1; win_x = 10'd3; win_y = 10'd2;
    run(FRAME);
    total++;
    if (frame_reads !== 0) begin bad++; check_int("pre_latch reads", frame_reads, 0); end
    run(FRAME);
    check_window("window", WW * WH, 3, 2);
    total++;
    if (last_h !== 8 || last_v !== 5) begin
      bad++;
      $display("FAIL window last_read: got (%0d,%0d) want (8,5)", last_h, last_v);
    end
  endtask

  task automatic test_underflow();
    ex = 4; ey = 3; empty_armed = 1;
    run(FRAME);
    // row 2 gives 6 reads, row 3 one read before the hole at x=4
    total++;
    if (frame_reads !== 7) begin bad++; check_int("underflow reads", frame_reads, 7); end
    total++;
    if (underflow_cnt !== 16'd1) begin bad++; check_int("underflow count", int'(underflow_cnt), 1); end
    run(FRAME);
    check_window("after_drop", WW * WH, 3, 2);
  endtask

  task automatic test_clamp();
    win_x = 10'd50; win_y = 10'd40;
    run(FRAME);
    run(FRAME);
    check_window("clamp", WW * WH, HA - WW, VA - WH);
    total++;
    if (last_h !== HA - 1 || last_v !== VA - 1) begin
      bad++;
      $display("FAIL clamp last_read: got (%0d,%0d) want (%0d,%0d)", last_h, last_v, HA - 1, VA - 1);
    end
  endtask

  task automatic test_midframe_cfg();
    win_x = 10'd3; win_y = 10'd2;
    run(FRAME);
    run(100);
    win_x = 10'd7;
    run(FRAME - 100);
    check_window("cfg_same_frame", WW * WH, 3, 2);
    run(FRAME);
    check_window("cfg_next_frame", WW * WH, 7, 2);
  endtask

  task automatic test_reset_midframe();
    ex = 9; ey = 4; empty_armed = 1;
    run(FRAME);
    total++;
    if (underflow_cnt !== 16'd2) begin bad++; check_int("second underflow", int'(underflow_cnt), 2); end
    run(4 * HT + 10);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    run(FRAME);
    total++;
    if (frame_reads !== 0) begin bad++; check_int("post_reset idle reads", frame_reads, 0); end
    run(FRAME);
    check_window("post_reset", WW * WH, 7, 2);
  endtask

  initial begin
    reset_model();
    test_reset();
    test_mode0();
    test_window();
    test_underflow();
    test_clamp();
    test_midframe_cfg();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
